// File: rtl/answer_recorder_if.sv
// answer_recorder_if: keypad/control inputs and answer-store/display outputs of the recorder
interface answer_recorder_if #(
    parameter int NOTE_W = 4,
    parameter int SLOTS  = 8
);
    logic [NOTE_W-1:0]       key_in;
    logic                    clear;
    logic                    commit;
    logic [NOTE_W*SLOTS-1:0] data_out;
    logic                    write_enable;
    logic [3:0]              cur_index;
    logic [3:0]              max_index;
    logic                    full;
    logic                    overflow;

    modport master (
        input  key_in, clear, commit,
        output data_out, write_enable, cur_index, max_index, full, overflow
    );

    modport slave (
        output key_in, clear, commit,
        input  data_out, write_enable, cur_index, max_index, full, overflow
    );
endinterface

// File: rtl/answer_recorder.sv
// answer_recorder: debounces keypad notes, packs them per slot and publishes the answer on commit
module answer_recorder #(
    parameter int NOTE_W          = 4,
    parameter int SLOTS           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                clk,
    input logic                reset_n,
    answer_recorder_if.master  bus
);
    localparam int IW = $clog2(SLOTS);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [3:0] SLOTS_IDX = 4'(SLOTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REC, FULL, WRITE} state_t;

    state_t                       state;
    logic [NOTE_W-1:0]            key_s1, key_s2, cand, stable;
    logic [CNT_W-1:0]             cnt;
    logic                         press;
    logic [SLOTS-1:0][NOTE_W-1:0] buffer;
    logic [3:0]                   cur_index;

    assign bus.cur_index = cur_index;
    assign bus.full = cur_index == SLOTS_IDX;

    // two-flop synchroniser for the asynchronous keypad code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            key_s1 <= bus.key_in;
            key_s2 <= key_s1;
        end
    end

    // debounce: accept a code once it held for DEBOUNCE_CYCLES; strobe only on a 0 -> key transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s2 != cand) begin
                cand <= key_s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= cand;
                press  <= stable == '0 && cand != '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // recording FSM: clear beats WRITE/commit, commit beats press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            buffer           <= '0;
            cur_index        <= '0;
            bus.data_out     <= '0;
            bus.max_index    <= '0;
            bus.write_enable <= 1'b0;
            bus.overflow     <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            if (bus.clear || state == WRITE) begin
                state        <= IDLE;
                buffer       <= '0;
                cur_index    <= '0;
                bus.overflow <= 1'b0;
            end else if (bus.commit) begin
                if (state != IDLE) begin
                    state            <= WRITE;
                    bus.write_enable <= 1'b1;
                    bus.data_out     <= buffer;
                    bus.max_index    <= cur_index;
                end
            end else if (press) begin
                if (state == FULL) begin
                    bus.overflow <= 1'b1;
                end else begin
                    buffer[cur_index[IW-1:0]] <= stable;
                    cur_index <= cur_index + 4'd1;
                    state <= (cur_index + 4'd1 == SLOTS_IDX) ? FULL : REC;
                end
            end
        end
    end
endmodule

// File: tb/tb_answer_recorder.sv
// tb_answer_recorder: randomized and directed checks of answer_recorder against a note-level model
module tb_answer_recorder;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int wr_exp = 0;

    logic [3:0]  m_slot[8];
    int          m_cnt;
    logic        m_ovf;
    logic [31:0] m_data;
    logic [3:0]  m_max;
    logic [3:0]  m_stable;

    always #5 clk = ~clk;

    answer_recorder_if #(.NOTE_W(4), .SLOTS(8)) bus ();

    answer_recorder #(.NOTE_W(4), .SLOTS(8), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always @(negedge clk) if (bus.write_enable === 1'b1) wr_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r = r | ({28'd0, m_slot[i]} << (4 * i));
        return r;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_slot[i] = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        m_data = '0;
        m_max = '0;
        m_stable = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".cur"}, 32'(bus.cur_index), 32'(m_cnt));
        check({tag, ".full"}, 32'(bus.full), 32'(m_cnt == 8));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        check({tag, ".data"}, bus.data_out, m_data);
        check({tag, ".max"}, 32'(bus.max_index), 32'(m_max));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".cur"}, 32'(bus.cur_index), 0);
        check({tag, ".max"}, 32'(bus.max_index), 0);
        check({tag, ".data"}, bus.data_out, 0);
        check({tag, ".we"}, 32'(bus.write_enable), 0);
        check({tag, ".full"}, 32'(bus.full), 0);
        check({tag, ".ovf"}, 32'(bus.overflow), 0);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        bus.key_in = v;
        repeat (n) tick();
        if (m_stable == 0 && v != 0) begin
            if (m_cnt < 8) begin
                m_slot[m_cnt] = v;
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_stable = v;
        check_state("hold");
    endtask

    task automatic note(input logic [3:0] v);
        hold(v, 10);
        hold(0, 10);
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        if (m_cnt > 0) begin
            m_data = m_pack();
            m_max = 4'(m_cnt);
            m_clear();
            wr_exp++;
            check("commit.we", 32'(bus.write_enable), 1);
            check("commit.data", bus.data_out, m_data);
            check("commit.max", 32'(bus.max_index), 32'(m_max));
        end else begin
            check("commit_empty.we", 32'(bus.write_enable), 0);
        end
        tick();
        check("commit.we_drop", 32'(bus.write_enable), 0);
        check("commit.wr_count", wr_cnt, wr_exp);
        check_state("commit");
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        m_clear();
        check_state("clear");
    endtask

    initial begin
        bus.key_in = '0;
        bus.clear = 1'b0;
        bus.commit = 1'b0;
        m_reset();
        repeat (3) tick();
        check_zero("reset");
        reset_n = 1'b1;
        tick();

        // 1: three notes then commit
        note(3);
        note(5);
        note(1);
        do_commit();
        check("t1.data", bus.data_out, 32'h0000_0153);
        check("t1.max", 32'(bus.max_index), 3);

        // 2: bouncing key gives one press; nonzero -> nonzero is not a press
        for (int i = 0; i < 2; i++) begin
            bus.key_in = 4'd0;
            tick();
            tick();
            bus.key_in = 4'd7;
            tick();
            tick();
        end
        hold(7, 12);
        check("t2.one_press", 32'(bus.cur_index), 1);
        hold(9, 12);
        check("t2.no_second", 32'(bus.cur_index), 1);
        hold(0, 10);
        do_commit();
        check("t2.data", bus.data_out, 32'h0000_0007);

        // 3: nine presses fill and overflow
        for (int i = 1; i <= 9; i++) begin
            hold(4'(i), 10);
            if (i == 8) check("t3.full", 32'(bus.full), 1);
            hold(0, 10);
        end
        check("t3.ovf", 32'(bus.overflow), 1);
        do_commit();
        check("t3.data", bus.data_out, 32'h8765_4321);
        check("t3.max", 32'(bus.max_index), 8);
        check("t3.ovf_clr", 32'(bus.overflow), 0);

        // 4: clear wins over commit in the same cycle
        note(2);
        note(6);
        bus.clear = 1'b1;
        bus.commit = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.commit = 1'b0;
        check("t4.we", 32'(bus.write_enable), 0);
        tick();
        m_clear();
        check_state("t4");
        check("t4.wr_count", wr_cnt, wr_exp);
        check("t4.data_kept", bus.data_out, 32'h8765_4321);

        // 5: empty commit ignored; press during a held commit is dropped
        do_commit();
        note(2);
        bus.key_in = 4'd5;
        bus.commit = 1'b1;
        repeat (12) tick();
        bus.commit = 1'b0;
        m_data = m_pack();
        m_max = 4'(m_cnt);
        m_clear();
        wr_exp++;
        m_stable = 4'd5;
        hold(0, 10);
        check("t5.wr_count", wr_cnt, wr_exp);
        check("t5.max", 32'(bus.max_index), 1);

        // 6: reset mid-debounce and during WRITE
        note(4);
        bus.key_in = 4'd4;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_zero("t6.mid_debounce");
        bus.key_in = 4'd0;
        tick();
        reset_n = 1'b1;
        m_reset();
        hold(0, 10);
        note(3);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        check("t6.we", 32'(bus.write_enable), 1);
        reset_n = 1'b0;
        #1;
        check_zero("t6.write");
        tick();
        reset_n = 1'b1;
        m_reset();
        hold(0, 10);
        note(2);
        note(6);
        do_commit();
        check("t6.data", bus.data_out, 32'h0000_0062);

        // randomized mix of held keys, glitches, commits and clears
        for (int k = 0; k < 80; k++) begin
            int op = $urandom_range(0, 9);
            if (op < 7) begin
                logic [3:0] v = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                if ($urandom_range(0, 2) == 0) begin
                    bus.key_in = 4'($urandom_range(0, 15));
                    tick();
                end
                hold(v, $urandom_range(10, 14));
            end else if (op < 9) begin
                do_commit();
            end else begin
                do_clear();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
